width_splitter: RTL and testbench

WIDTH_SPLITTER -- requirements
Module: width_splitter

---
 rtl/width_splitter_if.sv | 32 +++
 rtl/width_splitter.sv | 126 ++++++++++++
 tb/tb_width_splitter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/width_splitter_if.sv
`default_nettype none
// ============================================================================
// Module      : width_splitter_if
// Description : Handshake bundle between an upstream word FIFO, the width
//               splitter and its downstream chunk consumer.
// Revision    : 1.0
// ============================================================================
interface width_splitter_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) ();
    logic [IN_WIDTH-1:0]  data_in;
    logic                 data_in_stb;
    logic                 data_in_ack;
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_stb;
    logic                 data_out_ack;
    logic                 data_out_last;

    // Environment side: drives the word and the downstream acknowledge.
    modport master (
        output data_in, data_in_stb, data_out_ack,
        input  data_in_ack, data_out, data_out_stb, data_out_last
    );

    // Splitter side.
    modport slave (
        input  data_in, data_in_stb, data_out_ack,
        output data_in_ack, data_out, data_out_stb, data_out_last
    );
endinterface
`default_nettype wire

// File: rtl/width_splitter.sv
`default_nettype none
// ============================================================================
// Module      : width_splitter
// Description : Splits each IN_WIDTH-bit word into IN_WIDTH/OUT_WIDTH chunks
//               emitted one per handshake; all outputs registered.
// Revision    : 1.0
// ============================================================================
module width_splitter #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    width_splitter_if.slave  bus
);
    localparam int c_ratio = IN_WIDTH / OUT_WIDTH;
    localparam int c_cnt_w = $clog2(c_ratio);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ratio - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_emit = 1'b1;

    logic [0:0]           r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_count, w_count_nxt;
    logic [IN_WIDTH-1:0]  r_word, w_word_nxt;
    logic [OUT_WIDTH-1:0] r_data_out, w_data_out_nxt;
    logic                 r_out_stb, w_out_stb_nxt;
    logic                 r_out_last, w_out_last_nxt;
    logic                 r_in_ack, w_in_ack_nxt;

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic [c_cnt_w-1:0]   w_count_inc;

    // Chunk k in emission order; MSB_FIRST reverses the physical slice order.
    function automatic logic [OUT_WIDTH-1:0] f_chunk(
        input logic [IN_WIDTH-1:0] word,
        input logic [c_cnt_w-1:0]  idx
    );
        int p;
        p = MSB_FIRST ? (c_ratio - 1 - int'(idx)) : int'(idx);
        return word[p*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign w_in_xfer   = (r_state == c_st_idle) & bus.data_in_stb & r_in_ack;
    assign w_out_xfer  = r_out_stb & bus.data_out_ack;
    assign w_count_inc = r_count + 1'b1;

    assign bus.data_in_ack   = r_in_ack;
    assign bus.data_out      = r_data_out;
    assign bus.data_out_stb  = r_out_stb;
    assign bus.data_out_last = r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_word     <= '0;
            r_data_out <= '0;
            r_out_stb  <= 1'b0;
            r_out_last <= 1'b0;
            r_in_ack   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_word     <= w_word_nxt;
            r_data_out <= w_data_out_nxt;
            r_out_stb  <= w_out_stb_nxt;
            r_out_last <= w_out_last_nxt;
            r_in_ack   <= w_in_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_in_xfer) w_state_nxt = c_st_emit;
            c_st_emit: if (w_out_xfer && (r_count == c_last)) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Computes the next value of every registered output and datapath register.
    always_comb begin
        w_count_nxt    = r_count;
        w_word_nxt     = r_word;
        w_data_out_nxt = r_data_out;
        w_out_stb_nxt  = r_out_stb;
        w_out_last_nxt = r_out_last;
        w_in_ack_nxt   = r_in_ack;
        case (r_state)
            c_st_idle: begin
                w_in_ack_nxt   = 1'b1;
                w_out_stb_nxt  = 1'b0;
                w_out_last_nxt = 1'b0;
                if (w_in_xfer) begin
                    w_word_nxt     = bus.data_in;
                    w_count_nxt    = '0;
                    w_data_out_nxt = f_chunk(bus.data_in, '0);
                    w_out_stb_nxt  = 1'b1;
                    w_out_last_nxt = 1'b0;
                    w_in_ack_nxt   = 1'b0;
                end
            end
            c_st_emit: begin
                w_in_ack_nxt = 1'b0;
                if (w_out_xfer) begin
                    if (r_count == c_last) begin
                        w_out_stb_nxt  = 1'b0;
                        w_out_last_nxt = 1'b0;
                        w_in_ack_nxt   = 1'b1;
                    end else begin
                        w_count_nxt    = w_count_inc;
                        w_data_out_nxt = f_chunk(r_word, w_count_inc);
                        w_out_last_nxt = (w_count_inc == c_last);
                    end
                end
            end
            default: begin
                w_in_ack_nxt = 1'b0;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_width_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_width_splitter
// Description : Directed and random checks of LSB-first and MSB-first
//               splitters against a chunk-queue model.
// Revision    : 1.0
// ============================================================================
module tb_width_splitter;
    localparam int IW = 32;
    localparam int OW = 8;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] din = '0;
    logic          din_stb = 1'b0;
    logic          dout_ack = 1'b1;

    always #5 clk = ~clk;

    width_splitter_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_l ();
    width_splitter_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_m ();

    assign bus_l.data_in      = din;
    assign bus_l.data_in_stb  = din_stb;
    assign bus_l.data_out_ack = dout_ack;
    assign bus_m.data_in      = din;
    assign bus_m.data_in_stb  = din_stb;
    assign bus_m.data_out_ack = dout_ack;

    width_splitter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );
    width_splitter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_words = 0;
    int n_last = 0;

    // Model: one entry per chunk still owed downstream (word, emission index).
    logic [IW-1:0] q_word[$];
    int            q_k[$];
    logic [OW-1:0] hold_l = '0;
    logic [OW-1:0] hold_m = '0;
    bit            prev_rst = 1'b1;
    int            in_cyc[$];
    logic [OW-1:0] log_l[$];
    logic [OW-1:0] log_m[$];

    function automatic logic [OW-1:0] slice(input logic [IW-1:0] w, input int p);
        logic [IW-1:0] s;
        s = w >> (p * OW);
        return s[OW-1:0];
    endfunction

    function automatic logic [31:0] pack4(input logic [OW-1:0] q[$], input int off);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (off + i < q.size()) v = (v << 8) | 32'(q[off+i]);
            else v = (v << 8) | 32'hEE;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic          exp_stb, exp_ack, exp_last;
        logic [OW-1:0] exp_l, exp_m;
        cyc++;
        exp_stb = (q_word.size() != 0);
        exp_ack = !prev_rst && !exp_stb;
        if (exp_stb) begin
            exp_l    = slice(q_word[0], q_k[0]);
            exp_m    = slice(q_word[0], R - 1 - q_k[0]);
            exp_last = (q_k[0] == R - 1);
        end else begin
            exp_l    = hold_l;
            exp_m    = hold_m;
            exp_last = 1'b0;
        end
        check("stb_l",  IW'(bus_l.data_out_stb),  IW'(exp_stb));
        check("ack_l",  IW'(bus_l.data_in_ack),   IW'(exp_ack));
        check("last_l", IW'(bus_l.data_out_last), IW'(exp_last));
        check("data_l", IW'(bus_l.data_out),      IW'(exp_l));
        check("stb_m",  IW'(bus_m.data_out_stb),  IW'(exp_stb));
        check("ack_m",  IW'(bus_m.data_in_ack),   IW'(exp_ack));
        check("last_m", IW'(bus_m.data_out_last), IW'(exp_last));
        check("data_m", IW'(bus_m.data_out),      IW'(exp_m));
        if (bus_l.data_out_stb && bus_l.data_out_last && dout_ack && !rst) n_last++;
        // Predict the effect of the coming rising edge; inputs are stable until then.
        if (rst) begin
            q_word.delete();
            q_k.delete();
            hold_l   = '0;
            hold_m   = '0;
            prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (exp_stb && dout_ack) begin
                hold_l = exp_l;
                hold_m = exp_m;
                log_l.push_back(exp_l);
                log_m.push_back(exp_m);
                void'(q_word.pop_front());
                void'(q_k.pop_front());
            end
            if (exp_ack && din_stb) begin
                for (int k = 0; k < R; k++) begin
                    q_word.push_back(din);
                    q_k.push_back(k);
                end
                in_cyc.push_back(cyc);
                n_words++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] w);
        bit done;
        done    = 1'b0;
        din     = w;
        din_stb = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            done = bus_l.data_in_ack;
            step();
        end
        din_stb = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept word=%h", w);
        end
    endtask

    task automatic clear_logs();
        log_l.delete();
        log_m.delete();
        in_cyc.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single word, downstream always ready.
        clear_logs();
        send(32'hAABBCCDD);
        repeat (6) step();
        check("t1_size", IW'(log_l.size()), 4);
        check("t1_lsb_seq", pack4(log_l, 0), 32'hDDCCBBAA);
        check("t1_msb_seq", pack4(log_m, 0), 32'hAABBCCDD);

        // Backpressure while 0xCC is presented.
        clear_logs();
        send(32'hAABBCCDD);
        step();
        dout_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data", IW'(bus_l.data_out), 32'hCC);
            check("bp_stb",  IW'(bus_l.data_out_stb), 1);
            check("bp_last", IW'(bus_l.data_out_last), 0);
            step();
        end
        dout_ack = 1'b1;
        repeat (6) step();
        check("bp_size", IW'(log_l.size()), 4);
        check("bp_seq", pack4(log_l, 0), 32'hDDCCBBAA);

        // Back-to-back words with stb held high.
        clear_logs();
        send(32'h03020100);
        send(32'h07060504);
        repeat (6) step();
        check("b2b_size", IW'(log_l.size()), 8);
        check("b2b_lsb_w0", pack4(log_l, 0), 32'h00010203);
        check("b2b_lsb_w1", pack4(log_l, 4), 32'h04050607);
        check("b2b_msb_w0", pack4(log_m, 0), 32'h03020100);
        check("b2b_msb_w1", pack4(log_m, 4), 32'h07060504);
        if (in_cyc.size() == 2) check("b2b_gap", IW'(in_cyc[1] - in_cyc[0]), 5);
        else check("b2b_accepts", IW'(in_cyc.size()), 2);

        // Reset in the middle of a word.
        clear_logs();
        send(32'h44332211);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_stb", IW'(bus_l.data_out_stb), 0);
        check("rst_ack0", IW'(bus_l.data_in_ack), 0);
        step();
        @(negedge clk);
        check("rst_ack1", IW'(bus_l.data_in_ack), 1);
        step();
        send(32'h88776655);
        repeat (6) step();
        check("rst_size", IW'(log_l.size()), 5);
        check("rst_first", pack4(log_l, 0), 32'h11556677);
        check("rst_msb_first", pack4(log_m, 0), 32'h44887766);

        // Random soak.
        n_words = 0;
        n_last  = 0;
        for (int i = 0; i < 400; i++) begin
            din_stb  = ($urandom_range(0, 3) != 0);
            din      = $urandom;
            dout_ack = ($urandom_range(0, 3) != 0);
            step();
        end
        din_stb  = 1'b0;
        dout_ack = 1'b1;
        for (int i = 0; i < 20 && q_word.size() != 0; i++) step();
        step();
        check("soak_drained", IW'(q_word.size()), 0);
        check("soak_last_count", IW'(n_last), IW'(n_words));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
